// File: rtl/branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module  : branch_predictor_if
// Purpose : Fetch-side lookup and execute-side resolution signals of one
//           per-core branch predictor.
// Revision: 1.0 - initial release
// ============================================================================
interface branch_predictor_if;
  logic [31:0] pc;
  logic        stall_fetch_now;
  logic        hlt;
  logic        prediction;
  logic [31:0] branch;
  logic        res_valid;
  logic        res_branch;
  logic        res_taken;
  logic [31:0] res_target;
  logic        wrong;
  logic [31:0] correct_pc;
  logic [15:0] mispredict_count;

  modport slave (
    input  pc, stall_fetch_now, hlt,
    input  res_valid, res_branch, res_taken, res_target,
    output prediction, branch, wrong, correct_pc, mispredict_count
  );

  modport master (
    output pc, stall_fetch_now, hlt,
    output res_valid, res_branch, res_taken, res_target,
    input  prediction, branch, wrong, correct_pc, mispredict_count
  );
endinterface
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module  : branch_predictor
// Purpose : 2-bit counter + BTB predictor with an in-flight queue that checks
//           each resolved instruction against its recorded prediction.
// Revision: 1.0 - initial release
// ============================================================================
module branch_predictor #(
  parameter int INDEX_BITS = 6,
  parameter int TAG_BITS   = 8,
  parameter int PIPE_DEPTH = 2
) (
  input  wire logic          clk,
  input  wire logic          reset,
  branch_predictor_if.slave  bp
);

  localparam int ENTRIES = 1 << INDEX_BITS;

  // Prediction tables
  logic [ENTRIES-1:0][1:0]          r_cnt;
  logic [ENTRIES-1:0]               r_btb_valid;
  logic [ENTRIES-1:0][TAG_BITS-1:0] r_btb_tag;
  logic [ENTRIES-1:0][31:0]         r_btb_target;

  // In-flight queue; entry PIPE_DEPTH-1 is the head
  logic [PIPE_DEPTH-1:0]       r_q_valid;
  logic [PIPE_DEPTH-1:0][31:0] r_q_pc;
  logic [PIPE_DEPTH-1:0]       r_q_pred;
  logic [PIPE_DEPTH-1:0][31:0] r_q_target;

  logic [15:0] r_mispredict_count;

  logic [INDEX_BITS-1:0] w_idx;
  logic [TAG_BITS-1:0]   w_tag;
  logic                  w_pred;
  logic [31:0]           w_branch;

  logic                  w_head_valid;
  logic [31:0]           w_head_pc;
  logic                  w_head_pred;
  logic [31:0]           w_head_target;
  logic [INDEX_BITS-1:0] w_head_idx;
  logic [TAG_BITS-1:0]   w_head_tag;
  logic [1:0]            w_head_cnt;

  logic w_active;
  logic w_mispred_branch;
  logic w_wrong;
  logic [31:0] w_correct_pc;

  // Lookup
  assign w_idx    = bp.pc[INDEX_BITS+1:2];
  assign w_tag    = bp.pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign w_pred   = r_btb_valid[w_idx] & (r_btb_tag[w_idx] == w_tag) & r_cnt[w_idx][1];
  assign w_branch = w_pred ? r_btb_target[w_idx] : (bp.pc + 32'd4);

  assign w_head_valid  = r_q_valid[PIPE_DEPTH-1];
  assign w_head_pc     = r_q_pc[PIPE_DEPTH-1];
  assign w_head_pred   = r_q_pred[PIPE_DEPTH-1];
  assign w_head_target = r_q_target[PIPE_DEPTH-1];
  assign w_head_idx    = w_head_pc[INDEX_BITS+1:2];
  assign w_head_tag    = w_head_pc[INDEX_BITS+TAG_BITS+1:INDEX_BITS+2];
  assign w_head_cnt    = r_cnt[w_head_idx];

  // Check against the recorded prediction of the queue head
  assign w_active         = bp.res_valid & w_head_valid & ~bp.stall_fetch_now;
  assign w_mispred_branch = (bp.res_taken != w_head_pred) |
                            (bp.res_taken & (bp.res_target != w_head_target));
  assign w_wrong          = w_active & (bp.res_branch ? w_mispred_branch : w_head_pred);
  assign w_correct_pc     = (bp.res_taken & bp.res_branch) ? bp.res_target
                                                           : (w_head_pc + 32'd4);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q_valid  <= '0;
      r_q_pc     <= '0;
      r_q_pred   <= '0;
      r_q_target <= '0;
    end else if (!bp.stall_fetch_now) begin
      // A redirect squashes everything in flight, including this cycle's fetch
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        r_q_valid[i]  <= r_q_valid[i-1] & ~w_wrong;
        r_q_pc[i]     <= r_q_pc[i-1];
        r_q_pred[i]   <= r_q_pred[i-1];
        r_q_target[i] <= r_q_target[i-1];
      end
      r_q_valid[0]  <= ~bp.hlt & ~w_wrong;
      r_q_pc[0]     <= bp.pc;
      r_q_pred[0]   <= w_pred;
      r_q_target[0] <= w_branch;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt        <= {ENTRIES{2'b01}};
      r_btb_valid  <= '0;
      r_btb_tag    <= '0;
      r_btb_target <= '0;
    end else if (w_active) begin
      if (bp.res_branch) begin
        if (bp.res_taken) begin
          if (w_head_cnt != 2'b11) begin
            r_cnt[w_head_idx] <= w_head_cnt + 2'd1;
          end
          r_btb_valid[w_head_idx]  <= 1'b1;
          r_btb_tag[w_head_idx]    <= w_head_tag;
          r_btb_target[w_head_idx] <= bp.res_target;
        end else if (w_head_cnt != 2'b00) begin
          r_cnt[w_head_idx] <= w_head_cnt - 2'd1;
        end
      end else if (w_head_pred) begin
        // A non-branch hit the BTB through an alias: drop the entry
        r_btb_valid[w_head_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mispredict_count <= '0;
    end else if (w_wrong && (r_mispredict_count != 16'hFFFF)) begin
      r_mispredict_count <= r_mispredict_count + 16'd1;
    end
  end

  assign bp.prediction       = w_pred;
  assign bp.branch           = w_branch;
  assign bp.wrong            = w_wrong;
  assign bp.correct_pc       = w_correct_pc;
  assign bp.mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire
